box_move_renderer: RTL

- Pixel sequencer between the game/board FSM and vga_adapter.
- On each start request it erases the box at its previous position with the background colour, then draws it at the new position in the requested colour.
- Emits one pixel per clock as x/y/colour/plot for vga_adapter (320x240, 3-bit colour).
- Replaces ad-hoc draw/finished wiring with a clean start/busy/done handshake.

---
 rtl/box_move_renderer_if.sv | 15 +
 rtl/box_move_renderer.sv | 104 ++++++++++
 2 files changed

// File: rtl/box_move_renderer_if.sv
// box_move_renderer_if: start/busy/done handshake plus pixel bus toward vga_adapter
interface box_move_renderer_if;
  logic       start;
  logic [9:0] new_x;
  logic [8:0] new_y;
  logic [2:0] box_colour;
  logic       busy;
  logic       done;
  logic [9:0] x_out;
  logic [8:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  modport master (output start, new_x, new_y, box_colour, input busy, done, x_out, y_out, colour_out, plot);
  modport slave (input start, new_x, new_y, box_colour, output busy, done, x_out, y_out, colour_out, plot);
endinterface

// File: rtl/box_move_renderer.sv
// box_move_renderer: erases the box at its old position, then draws it at the new one, one pixel per clock
module box_move_renderer #(
  parameter int         BOX_W     = 10,
  parameter int         BOX_H     = 10,
  parameter int         SCREEN_W  = 320,
  parameter int         SCREEN_H  = 240,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input logic clock,
  input logic reset,
  box_move_renderer_if.slave bus
);
  localparam logic [5:0]  XL = 6'(BOX_W - 1);
  localparam logic [5:0]  YL = 6'(BOX_H - 1);
  localparam logic [10:0] SW = 11'(SCREEN_W);
  localparam logic [9:0]  SH = 10'(SCREEN_H);
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;
  state_t      state_q, state_d;
  logic [5:0]  ox_q, ox_d, oy_q, oy_d;
  logic [9:0]  lat_x_q, prev_x_q, x_q, x_d;
  logic [8:0]  lat_y_q, prev_y_q, y_q, y_d;
  logic [2:0]  lat_c_q, c_q, c_d;
  logic        prev_v_q, busy_q, busy_d, done_q, done_d, plot_q, plot_d;
  logic        erase, scan, row_end, last;
  logic [10:0] sum_x;
  logic [9:0]  sum_y;
  assign erase   = state_q == ERASE;
  assign scan    = erase || state_q == DRAW;
  assign row_end = ox_q == XL;
  assign last    = row_end && oy_q == YL;
  // sums are one bit wider than the outputs so clipping sees the untruncated coordinate
  assign sum_x   = {1'b0, erase ? prev_x_q : lat_x_q} + {5'b0, ox_q};
  assign sum_y   = {1'b0, erase ? prev_y_q : lat_y_q} + {4'b0, oy_q};
  // state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state: erase only when a previous box exists
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = prev_v_q ? ERASE : DRAW;
      ERASE:   if (last) state_d = DRAW;
      DRAW:    if (last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // raster offsets and next values of the registered pixel/handshake outputs
  always_comb begin
    ox_d   = (!scan || row_end) ? '0 : ox_q + 6'd1;
    oy_d   = (!scan || last) ? '0 : oy_q + {5'b0, row_end};
    plot_d = scan && sum_x < SW && sum_y < SH;
    x_d    = scan ? sum_x[9:0] : x_q;
    y_d    = scan ? sum_y[8:0] : y_q;
    c_d    = erase ? BG_COLOUR : scan ? lat_c_q : c_q;
    done_d = state_q == DONE;
    busy_d = state_d != IDLE || state_q == DONE;
  end
  // datapath: latch request on acceptance, remember position on completion, register outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      ox_q     <= '0;
      oy_q     <= '0;
      lat_x_q  <= '0;
      lat_y_q  <= '0;
      lat_c_q  <= '0;
      prev_x_q <= '0;
      prev_y_q <= '0;
      prev_v_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      c_q      <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ox_q   <= ox_d;
      oy_q   <= oy_d;
      x_q    <= x_d;
      y_q    <= y_d;
      c_q    <= c_d;
      plot_q <= plot_d;
      busy_q <= busy_d;
      done_q <= done_d;
      if (state_q == IDLE && bus.start) begin
        lat_x_q <= bus.new_x;
        lat_y_q <= bus.new_y;
        lat_c_q <= bus.box_colour;
      end
      if (state_q == DONE) begin
        prev_x_q <= lat_x_q;
        prev_y_q <= lat_y_q;
        prev_v_q <= 1'b1;
      end
    end
  end
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.plot       = plot_q;
  assign bus.x_out      = x_q;
  assign bus.y_out      = y_q;
  assign bus.colour_out = c_q;
endmodule
